// File: rtl/memc_scan.sv
`default_nettype none
// ============================================================================
// Module   : memc_scan
// Purpose  : Pixel scan-order front end for a motion-compensation engine.
//            Pixels arrive either in block order or in raster order. Each
//            accepted pixel is written into a ping-pong frame store. The
//            frame slot is selected by bit 0 of the completed-frame count.
//            Block and frame completion pulses are aligned with the write of
//            the closing pixel.
// Revision : 1.0 - initial release
//
// Ports
//   clk          : sole clock; all logic runs on the rising edge
//   rst          : asynchronous active-high reset
//   pixel_valid  : pixel qualifier; a pixel is accepted when busy is low
//   pixel[7:0]   : sample data
//   scan_mode    : 0 = block-order input, 1 = raster input (sampled at the
//                  first pixel of each frame)
//   restart      : single-cycle pulse that leaves DONE
//   busy         : high in DONE; no pixels are accepted while high
//   wr_en        : frame-store write strobe (one cycle after acceptance)
//   wr_addr      : slot*IMG_W*IMG_H + y*IMG_W + x
//   wr_data      : pixel being written
//   blk_done     : pulses with the write of the bottom-right pixel of a block
//   blk_addr     : block index (y/BLK)*(IMG_W/BLK) + x/BLK, valid with blk_done
//   frame_done   : pulses with the write of pixel (IMG_W-1, IMG_H-1)
//   all_done     : pulses with the final frame_done of the sequence
//   frame_cnt    : number of completed frames
//   blk_cksum    : 16-bit wrapping block sum (block-order mode only)
//
// Build option
//   MEMC_SCAN_CKSUM_EN : when defined, the block checksum accumulator is
//                        built. Otherwise blk_cksum is tied to zero.
// ============================================================================
module memc_scan #(
   parameter int  IMG_W      = 64,
   parameter int  IMG_H      = 64,
   parameter int  BLK        = 8,
   parameter int  NUM_FRAMES = 10,
   localparam int AW         = $clog2(2 * IMG_W * IMG_H),
   localparam int BW         = (((IMG_W / BLK) * (IMG_H / BLK)) > 1) ?
                               $clog2((IMG_W / BLK) * (IMG_H / BLK)) : 1,
   localparam int FW         = $clog2(NUM_FRAMES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pixel_valid,
   input  logic [7:0]    pixel,
   input  logic          scan_mode,
   input  logic          restart,
   output logic          busy,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          blk_done,
   output logic [BW-1:0] blk_addr,
   output logic          frame_done,
   output logic          all_done,
   output logic [FW-1:0] frame_cnt,
   output logic [15:0]   blk_cksum
);

   localparam int XW        = $clog2(IMG_W);
   localparam int YW        = $clog2(IMG_H);
   localparam int LB        = $clog2(BLK);
   localparam int FRAME_PIX = IMG_W * IMG_H;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic            busy_q;
   logic            mode_q;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [FW-1:0]   frame_cnt_q;
   logic            wr_en_q;
   logic [AW-1:0]   wr_addr_q;
   logic [7:0]      wr_data_q;
   logic            blk_done_q;
   logic [BW-1:0]   blk_addr_q;
   logic            frame_done_q;
   logic            all_done_q;

   logic            accept;
   logic            mode_eff;
   logic            blk_x_end, blk_y_end;
   logic            row_end, col_end;
   logic            frame_end, blk_end, last_frame;
   logic [AW-1:0]   addr_d;
   logic [BW-1:0]   blk_addr_d;

   // ------------------------------------------------------------------
   // Position bookkeeping. (x_q, y_q) is the coordinate of the next pixel
   // to accept. Both scan orders end a frame at the bottom-right corner,
   // so the counters are at (0,0) exactly at each frame start.
   // ------------------------------------------------------------------
   always_comb begin
      accept     = pixel_valid && !busy_q;
      // The scan order is sampled only at the first pixel of a frame.
      mode_eff   = ((x_q == '0) && (y_q == '0)) ? scan_mode : mode_q;
      blk_x_end  = &x_q[LB-1:0];
      blk_y_end  = &y_q[LB-1:0];
      row_end    = (x_q == XW'(IMG_W - 1));
      col_end    = (y_q == YW'(IMG_H - 1));
      frame_end  = row_end && col_end;
      blk_end    = blk_x_end && blk_y_end;
      last_frame = (frame_cnt_q == FW'(NUM_FRAMES - 1));

      x_d = x_q;
      y_d = y_q;
      if (mode_eff) begin
         // Raster: x across the full row, then y.
         if (!row_end) begin
            x_d = x_q + XW'(1);
         end else begin
            x_d = '0;
            y_d = col_end ? '0 : y_q + YW'(1);
         end
      end else begin
         // Block order: x in block, y in block, block column, block row.
         if (!blk_x_end) begin
            x_d = x_q + XW'(1);
         end else if (!blk_y_end) begin
            x_d = x_q - XW'(BLK - 1);
            y_d = y_q + YW'(1);
         end else if (!row_end) begin
            x_d = x_q + XW'(1);
            y_d = y_q - YW'(BLK - 1);
         end else begin
            x_d = '0;
            y_d = col_end ? '0 : y_q + YW'(1);
         end
      end

      addr_d     = (frame_cnt_q[0] ? AW'(FRAME_PIX) : '0)
                 + AW'(y_q) * AW'(IMG_W) + AW'(x_q);
      blk_addr_d = BW'(y_q >> LB) * BW'(IMG_W / BLK) + BW'(x_q >> LB);
   end

   // ------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         mode_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         frame_cnt_q  <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         blk_done_q   <= 1'b0;
         blk_addr_q   <= '0;
         frame_done_q <= 1'b0;
         all_done_q   <= 1'b0;
      end else begin
         wr_en_q      <= 1'b0;
         blk_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
         all_done_q   <= 1'b0;
         case (state_q)
            S_IDLE, S_RUN: begin
               if (accept) begin
                  state_q    <= S_RUN;
                  mode_q     <= mode_eff;
                  x_q        <= x_d;
                  y_q        <= y_d;
                  wr_en_q    <= 1'b1;
                  wr_addr_q  <= addr_d;
                  wr_data_q  <= pixel;
                  blk_done_q <= blk_end;
                  if (blk_end) begin
                     blk_addr_q <= blk_addr_d;
                  end
                  if (frame_end) begin
                     frame_done_q <= 1'b1;
                     frame_cnt_q  <= frame_cnt_q + FW'(1);
                     if (last_frame) begin
                        all_done_q <= 1'b1;
                        state_q    <= S_DONE;
                        busy_q     <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               if (restart) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  frame_cnt_q <= '0;
                  x_q         <= '0;
                  y_q         <= '0;
                  mode_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MEMC_SCAN_CKSUM_EN
   // A block's pixels are contiguous in block order, so the running sum
   // restarts at each block's top-left pixel.
   logic [15:0] sum_q, sum_d;
   logic [15:0] blk_cksum_q;
   logic        blk_start;

   always_comb begin
      blk_start = (x_q[LB-1:0] == '0) && (y_q[LB-1:0] == '0);
      sum_d     = (blk_start ? 16'd0 : sum_q) + {8'd0, pixel};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         blk_cksum_q <= '0;
      end else begin
         if (accept) begin
            sum_q <= sum_d;
         end
         blk_cksum_q <= (accept && blk_end && !mode_eff) ? sum_d : 16'd0;
      end
   end

   assign blk_cksum = blk_cksum_q;
`else
   assign blk_cksum = 16'd0;
`endif

   assign busy       = busy_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign blk_done   = blk_done_q;
   assign blk_addr   = blk_addr_q;
   assign frame_done = frame_done_q;
   assign all_done   = all_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire
